// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: the zero-register
// index, the instruction latency classes and default result latencies.
package hazard_scoreboard_pkg;

  // Architectural zero register; writes are discarded and never tracked.
  localparam logic [4:0] XZR_IDX = 5'd31;

  // Default extra cycles before a result becomes forwardable.
  localparam int LOAD_LAT_DEF = 1;
  localparam int MUL_LAT_DEF  = 3;

  // Latency class of the instruction in ID; encoding 2'b11 is reserved
  // and behaves like an ALU op.
  typedef enum logic [1:0] {
    CLASS_ALU  = 2'd0,
    CLASS_LOAD = 2'd1,
    CLASS_MUL  = 2'd2
  } lat_class_e;

  // True when a register index refers to a tracked (non-XZR) register.
  function automatic logic is_tracked(input logic [4:0] idx);
    return (idx != XZR_IDX);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard slot: a countdown of cycles until the register's pending
// result becomes forwardable.
//   clk_i      pipeline clock
//   rst_ni     synchronous active-low reset
//   load_i     load a new latency (issue of a writer to this register)
//   load_val_i latency to load
//   pend_o     current countdown value
//   busy_o     countdown non-zero (result not forwardable this cycle)
module hazard_scoreboard_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] pend_o,
  output logic             busy_o
);

  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] pend_d;

  assign busy_o = (pend_q != {CNT_W{1'b0}});
  assign pend_o = pend_q;

  // Next countdown: a new issue overrides any countdown in progress;
  // otherwise decrement and hold at zero.
  always_comb begin
    pend_d = pend_q;
    if (load_i) begin
      pend_d = load_val_i;
    end else if (busy_o) begin
      pend_d = pend_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      pend_d = pend_q;
    end
  end

  // Countdown register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pend_q <= {CNT_W{1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard. Tracks in-flight writes whose results are not
// yet forwardable and stalls the ID consumer until EX forwarding can cover
// the dependency (load-use, multi-cycle multiply, WAW ordering).
//   CLK            pipeline clock
//   RESET_N        synchronous active-low reset
//   ID_*_IN        decoded fields of the instruction in ID
//   FLUSH_IN       branch flush: the ID instruction is killed
//   STALL          hazard this cycle
//   PC_WRITE       PC may advance (~STALL)
//   IFID_WRITE     IF/ID may load (~STALL)
//   IDEX_BUBBLE    zero ID/EX controls (STALL or FLUSH_IN)
//   STALL_COUNT    saturating stall-cycle counter
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = LOAD_LAT_DEF,
  parameter int MUL_LAT  = MUL_LAT_DEF,
  parameter int CNT_W    = 2,
  parameter int PERF_W   = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ID_VALID_IN,
  input  logic [4:0]        ID_RN1_IN,
  input  logic [4:0]        ID_RM2_IN,
  input  logic              ID_USES_RN_IN,
  input  logic              ID_USES_RM_IN,
  input  logic [4:0]        ID_RD_IN,
  input  logic              ID_REGWRITE_IN,
  input  logic [1:0]        ID_CLASS_IN,
  input  logic              FLUSH_IN,
  output logic              STALL,
  output logic              PC_WRITE,
  output logic              IFID_WRITE,
  output logic              IDEX_BUBBLE,
  output logic [PERF_W-1:0] STALL_COUNT
);

  // Countdown of every register; the XZR slot is tied to zero so that a
  // lookup of register 31 can never report a pending write.
  logic [CNT_W-1:0] pend_all_s [NUM_REGS];
  logic             busy_s     [NUM_REGS];

  logic [CNT_W-1:0] new_lat_s;
  logic             raw_rn_s;
  logic             raw_rm_s;
  logic             waw_s;
  logic             stall_s;
  logic             issue_s;

  logic [PERF_W-1:0] perf_cnt_q;
  logic [PERF_W-1:0] perf_cnt_d;

  // Latency loaded into the destination slot on issue.
  always_comb begin
    new_lat_s = {CNT_W{1'b0}};
    case (ID_CLASS_IN)
      CLASS_LOAD: new_lat_s = CNT_W'(LOAD_LAT);
      CLASS_MUL:  new_lat_s = CNT_W'(MUL_LAT);
      default:    new_lat_s = {CNT_W{1'b0}};
    endcase
  end

  // Hazard detection. A source equal to this instruction's own rd is only
  // checked against older pending writes, since the slot loads after issue.
  // WAW stalls while an older write would still land after this one.
  always_comb begin
    raw_rn_s = ID_VALID_IN & ID_USES_RN_IN & is_tracked(ID_RN1_IN) & busy_s[ID_RN1_IN];
    raw_rm_s = ID_VALID_IN & ID_USES_RM_IN & is_tracked(ID_RM2_IN) & busy_s[ID_RM2_IN];
    waw_s    = ID_VALID_IN & ID_REGWRITE_IN & is_tracked(ID_RD_IN)
             & (pend_all_s[ID_RD_IN] > new_lat_s);
    // A flushed instruction is dead: it neither stalls nor issues.
    stall_s  = (raw_rn_s | raw_rm_s | waw_s) & ~FLUSH_IN;
    issue_s  = ID_VALID_IN & ~stall_s & ~FLUSH_IN & ID_REGWRITE_IN & is_tracked(ID_RD_IN);
  end

  genvar r;
  generate
    for (r = 0; r < NUM_REGS - 1; r++) begin : g_entry
      hazard_scoreboard_entry #(
        .CNT_W (CNT_W)
      ) u_scoreboard_entry (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .load_i     (issue_s && (ID_RD_IN == 5'(r))),
        .load_val_i (new_lat_s),
        .pend_o     (pend_all_s[r]),
        .busy_o     (busy_s[r])
      );
    end
  endgenerate

  assign pend_all_s[NUM_REGS-1] = {CNT_W{1'b0}};
  assign busy_s[NUM_REGS-1]     = 1'b0;

  // Stall counter next state, holding at all-ones.
  always_comb begin
    perf_cnt_d = perf_cnt_q;
    if (stall_s && (perf_cnt_q != {PERF_W{1'b1}})) begin
      perf_cnt_d = perf_cnt_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      perf_cnt_d = perf_cnt_q;
    end
  end

  // Stall counter register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      perf_cnt_q <= {PERF_W{1'b0}};
    end else begin
      perf_cnt_q <= perf_cnt_d;
    end
  end

  // Pipeline controls are a direct function of state and the ID inputs so
  // that the stall takes effect in the same cycle it is detected.
  assign STALL       = stall_s;
  assign PC_WRITE    = ~stall_s;
  assign IFID_WRITE  = ~stall_s;
  assign IDEX_BUBBLE = stall_s | FLUSH_IN;
  assign STALL_COUNT = perf_cnt_q;

endmodule
